// File: rtl/shift_reg_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer: FSM encoding, shift
// limit and the count clamp helper.
package shift_reg_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_SHIFT     = DEFAULT_WIDTH;

    // Requests longer than the register width behave as a full-width shift.
    function automatic int unsigned clamp_count(input logic [3:0] cnt,
                                                input int unsigned max_shift);
        int unsigned c;
        c = int'(cnt);
        return (c > max_shift) ? max_shift : c;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer.sv
// Drives an external parallel-load shift register: loads a value, shifts it N
// times in the requested direction, captures the result, then keeps it frozen.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int WIDTH = MAX_SHIFT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             dir,
    input  logic [3:0]       shift_count,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] i,
    output logic             load_enable,
    output logic             shift_left_right,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output state_e           dbg_state_o
);

    localparam int CW = ($clog2(WIDTH + 1) > 4) ? $clog2(WIDTH + 1) : 4;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [CW-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_clamped;

    assign count_clamped = CW'(clamp_count(shift_count, WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            dir_q    <= 1'b0;
            rem_q    <= '0;
            hold_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            hold_q   <= hold_d;
            result_q <= result_d;
        end
    end

    // Outside SHIFT the register is always parallel-loaded; IDLE feeds back
    // the captured value so its contents stay frozen.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        dir_d       = dir_q;
        rem_d       = rem_q;
        hold_d      = hold_q;
        result_d    = result_q;
        i           = hold_q;
        load_enable = 1'b0;
        done        = 1'b0;
        busy        = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                i = hold_q;
                if (start) begin
                    data_d  = data_in;
                    dir_d   = dir;
                    rem_d   = count_clamped;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                i       = data_q;
                state_d = (rem_q == '0) ? ST_CAPTURE : ST_SHIFT;
            end
            ST_SHIFT: begin
                i           = data_q;
                load_enable = 1'b1;
                rem_d       = rem_q - 1'b1;
                if (rem_q <= CW'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                i        = q_in;
                done     = 1'b1;
                result_d = q_in;
                hold_d   = q_in;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign shift_left_right = dir_q;
    assign result           = result_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer driving a behavioural load/shift register.
module tb_shift_reg_sequencer;
    import shift_reg_sequencer_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] data_in;
    logic         dir;
    logic [3:0]   shift_count;
    logic [W-1:0] reg_q;
    logic [W-1:0] i_w;
    logic         load_enable;
    logic         shift_left_right;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    state_e       dbg_state;

    int errors = 0;
    int checks = 0;

    shift_reg_sequencer #(.WIDTH(W)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .data_in          (data_in),
        .dir              (dir),
        .shift_count      (shift_count),
        .q_in             (reg_q),
        .i                (i_w),
        .load_enable      (load_enable),
        .shift_left_right (shift_left_right),
        .busy             (busy),
        .done             (done),
        .result           (result),
        .dbg_state_o      (dbg_state)
    );

    // Clock and the downstream shift register (active-low load, dir 1 = right)
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          reg_q <= '0;
        else if (!load_enable) reg_q <= i_w;
        else if (shift_left_right) reg_q <= reg_q >> 1;
        else                   reg_q <= reg_q << 1;
    end

    // Driver: issue one request from a negedge, then watch for done; returns
    // the cycle offset of done (start edge = k, LOAD = offset 1) and the number
    // of done pulses, finishing at the negedge of the first idle cycle.
    task automatic run_op(input logic [W-1:0] d, input logic dr, input logic [3:0] cnt,
                          output int done_at, output int n_done);
        done_at     = -1;
        n_done      = 0;
        data_in     = d;
        dir         = dr;
        shift_count = cnt;
        start       = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && !busy) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; data_in = '0; dir = 1'b0; shift_count = '0;
        repeat (3) @(negedge clk);
        checks++; if (i_w !== 8'h00) begin errors++; $display("FAIL reset_i got=%h exp=00", i_w); end
        checks++; if (load_enable !== 1'b0) begin errors++; $display("FAIL reset_load_enable got=%b exp=0", load_enable); end
        checks++; if (shift_left_right !== 1'b0) begin errors++; $display("FAIL reset_slr got=%b exp=0", shift_left_right); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (reg_q !== 8'h00) begin errors++; $display("FAIL idle_reg got=%h exp=00", reg_q); end
    endtask

    task automatic test_shift_left_one();
        int da, nd;
        run_op(8'h81, 1'b0, 4'd1, da, nd);
        checks++; if (da !== 3) begin errors++; $display("FAIL left1_done_cycle got=%0d exp=3", da); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL left1_done_pulses got=%0d exp=1", nd); end
        checks++; if (result !== 8'h02) begin errors++; $display("FAIL left1_result got=%h exp=02", result); end
    endtask

    task automatic test_shift_right_three();
        int da, nd;
        logic held;
        run_op(8'hF0, 1'b1, 4'd3, da, nd);
        checks++; if (da !== 5) begin errors++; $display("FAIL right3_done_cycle got=%0d exp=5", da); end
        checks++; if (result !== 8'h1E) begin errors++; $display("FAIL right3_result got=%h exp=1E", result); end
        checks++; if (shift_left_right !== 1'b1) begin errors++; $display("FAIL right3_dir_hold got=%b exp=1", shift_left_right); end
        held = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (reg_q !== 8'h1E || load_enable !== 1'b0 || busy !== 1'b0) held = 1'b0;
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL right3_frozen got=%h exp=1E", reg_q); end
    endtask

    task automatic test_count_zero();
        int da, nd;
        run_op(8'hA5, 1'b0, 4'd0, da, nd);
        checks++; if (da !== 2) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=2", da); end
        checks++; if (result !== 8'hA5) begin errors++; $display("FAIL zero_result got=%h exp=A5", result); end
    endtask

    task automatic test_clamp();
        int da, nd;
        run_op(8'hFF, 1'b0, 4'd12, da, nd);
        checks++; if (da !== 10) begin errors++; $display("FAIL clamp12_done_cycle got=%0d exp=10", da); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL clamp12_result got=%h exp=00", result); end
        run_op(8'h80, 1'b1, 4'd7, da, nd);
        checks++; if (da !== 9) begin errors++; $display("FAIL right7_done_cycle got=%0d exp=9", da); end
        checks++; if (result !== 8'h01) begin errors++; $display("FAIL right7_result got=%h exp=01", result); end
        run_op(8'hC3, 1'b1, 4'd15, da, nd);
        checks++; if (da !== 10) begin errors++; $display("FAIL clamp15_done_cycle got=%0d exp=10", da); end
        checks++; if (result !== 8'h00) begin errors++; $display("FAIL clamp15_result got=%h exp=00", result); end
    endtask

    task automatic test_ignored_start();
        int da, nd;
        da = -1; nd = 0;
        data_in = 8'hF0; dir = 1'b1; shift_count = 4'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; data_in = 8'h55; dir = 1'b0; shift_count = 4'd1;
            end
            if (c == 3) start = 1'b0;
            if (done) begin
                nd++;
                if (da < 0) da = c;
            end
        end
        checks++; if (da !== 5) begin errors++; $display("FAIL busy_start_done_cycle got=%0d exp=5", da); end
        checks++; if (nd !== 1) begin errors++; $display("FAIL busy_start_done_pulses got=%0d exp=1", nd); end
        checks++; if (result !== 8'h1E) begin errors++; $display("FAIL busy_start_result got=%h exp=1E", result); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int da, nd;
        int n_done_rst;
        data_in = 8'hF0; dir = 1'b1; shift_count = 4'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (load_enable !== 1'b0 || busy !== 1'b1 || i_w !== 8'hF0) begin
            errors++; $display("FAIL load_cycle got=le%b busy%b i%h exp=le0 busy1 iF0", load_enable, busy, i_w);
        end
        @(negedge clk);
        @(negedge clk);
        checks++; if (load_enable !== 1'b1 || shift_left_right !== 1'b1) begin
            errors++; $display("FAIL shift_cycle got=le%b slr%b exp=le1 slr1", load_enable, shift_left_right);
        end
        reset_n = 1'b0;
        #1;
        checks++; if (i_w !== 8'h00 || load_enable !== 1'b0 || shift_left_right !== 1'b0 ||
                      busy !== 1'b0 || done !== 1'b0 || result !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs got=i%h le%b slr%b busy%b done%b res%h exp=all zero",
                     i_w, load_enable, shift_left_right, busy, done, result);
        end
        n_done_rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) n_done_rst++;
        end
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (done) n_done_rst++;
        end
        checks++; if (n_done_rst !== 0) begin errors++; $display("FAIL mid_reset_no_done got=%0d exp=0", n_done_rst); end
        checks++; if (reg_q !== 8'h00) begin errors++; $display("FAIL mid_reset_reg got=%h exp=00", reg_q); end
        run_op(8'h3C, 1'b1, 4'd2, da, nd);
        checks++; if (da !== 4) begin errors++; $display("FAIL after_reset_done_cycle got=%0d exp=4", da); end
        checks++; if (result !== 8'h0F) begin errors++; $display("FAIL after_reset_result got=%h exp=0F", result); end
    endtask

    task automatic test_back_to_back();
        int da, nd;
        run_op(8'h0F, 1'b0, 4'd4, da, nd);
        checks++; if (da !== 6) begin errors++; $display("FAIL b2b_first_done_cycle got=%0d exp=6", da); end
        checks++; if (result !== 8'hF0) begin errors++; $display("FAIL b2b_first_result got=%h exp=F0", result); end
        run_op(8'h3C, 1'b1, 4'd2, da, nd);
        checks++; if (da !== 4) begin errors++; $display("FAIL b2b_second_done_cycle got=%0d exp=4", da); end
        checks++; if (result !== 8'h0F) begin errors++; $display("FAIL b2b_second_result got=%h exp=0F", result); end
        @(negedge clk);
        checks++; if (reg_q !== 8'h0F) begin errors++; $display("FAIL b2b_reg_hold got=%h exp=0F", reg_q); end
    endtask

    initial begin
        test_reset();
        test_shift_left_one();
        test_shift_right_three();
        test_count_zero();
        test_clamp();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
